spi_register_peripheral: RTL and testbench
==========================================

// Module: spi_register_peripheral
// PURPOSE
//   SPI Mode-0 responder that receives host write transactions and drives the
//   five PWM control registers (en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
//   en_reg_pwm_15_8, pwm_duty_cycle) consumed by pwm_peripheral. Sits in the top
//   level between ui_in pins (SCLK/COPI/nCS) and pwm_peripheral_inst.
// PARAMETERS
//   SYNC_STAGES  2    flops per synchronizer on sclk/copi/ncs (>=2)
//   MAX_ADDR     4    highest valid register address; higher addresses ignored
// PORTS
//   clk              in   1  system clock (>= 4x SCLK)
//   rst_n            in   1  async active-low reset
//   sclk             in   1  SPI clock from host, async
//   copi             in   1  host-to-peripheral data, async
//   ncs              in   1  active-low chip select, async
//   cipo             out  1  peripheral-to-host data (SPI_READBACK_EN only)
//   cipo_oe          out  1  output enable for cipo pad
//   en_reg_out_7_0   out  8  register 0x00
//   en_reg_out_15_8  out  8  register 0x01
//   en_reg_pwm_7_0   out  8  register 0x02
//   en_reg_pwm_15_8  out  8  register 0x03
//   pwm_duty_cycle   out  8  register 0x04
// BEHAVIOUR
//   - Reset: all five registers 8'h00; cipo=0; cipo_oe=0; bit count 0; FSM IDLE.
//   - Inputs pass SYNC_STAGES-flop synchronizers; edges detected in clk domain
//     from last two synced samples. All logic on posedge clk.
//   - Frame: 16 bits MSB first = {rw[15], addr[14:8], data[7:0]}; rw=1 write.
//   - COPI sampled on synced SCLK rising edge, shifted into 16-bit shift reg.
//   - FSM IDLE: ncs falling edge -> SHIFT, clear shift reg and bit count.
//   - SHIFT: each SCLK rise shifts 1 bit; count saturates at 17 (overrun flag).
//     ncs rising edge -> COMMIT.
//   - COMMIT (1 cycle): write iff count==16 && rw==1 && addr<=MAX_ADDR; target
//     register updated on the clk edge leaving COMMIT; then IDLE.
//   - Latency: register visible <= SYNC_STAGES+2 clk after pin nCS rises.
//   - Short (<16) or long (>16) frames, rw=0 writes, bad addr: discarded, no
//     register changes.
//   - SCLK edges while ncs high ignored. ncs low at reset exit: wait for a fresh
//     falling edge.
//   - Async reset mid-frame aborts; registers return to 0.
//   - Only one register written per frame; untouched registers hold.
// CONFIGURATION
//   SPI_READBACK_EN defined:
//     - rw=0 frame: after 8th SCLK rise (addr complete), load selected register
//       (8'h00 if addr>MAX_ADDR) into tx shift reg; cipo updated on each synced
//       SCLK falling edge, MSB first, bits 7..0 over frame bits 8..15.
//     - cipo_oe=1 while in SHIFT; 0 otherwise; cipo=0 outside data phase.
//   SPI_READBACK_EN undefined:
//     - cipo and cipo_oe tied 0; read frames fully ignored; no tx logic.
// TESTING
//   1. Reset, write 0x80FF (addr0,data FF) -> en_reg_out_7_0=FF, others 00.
//   2. Write 0x8440 -> pwm_duty_cycle=40 within SYNC_STAGES+2 clk of nCS rise.
//   3. Write 0x8555 (addr5) and 0x0177 (rw=0) -> all registers unchanged.
//   4. 15-bit frame and 17-bit frame of 0x83AA -> en_reg_pwm_15_8 stays 00.
//   5. rst_n low mid-frame after reg0=FF -> all regs 00; next 0x8122 -> reg1=22.
//   6. SPI_READBACK_EN: write 0x8233, then read 0x0200 -> cipo shifts 8'h33,
//      cipo_oe high during frame; without macro cipo_oe stays 0.

Source files
------------

// File: rtl/spi_register_peripheral.sv
// SPI Mode-0 write responder driving the five PWM control registers.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_register_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       cipo_oe,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // sclk and ncs carry one flop beyond the synchronizer so edges can be detected.
    logic [SYNC_STAGES:0]   r_sclk_sync;
    logic [SYNC_STAGES:0]   r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;

    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic [7:0]  r_regs [0:4];

    logic       w_sclk_rise;
    logic       w_ncs_rise;
    logic       w_ncs_fall;
    logic       w_copi;
    logic       w_shift_bit;
    logic [6:0] w_addr;
    logic       w_commit_ok;

    // ncs history resets low so a pin held low through reset never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '0;
            r_copi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-1:0], ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
    assign w_ncs_rise  = r_ncs_sync[SYNC_STAGES-1]  & ~r_ncs_sync[SYNC_STAGES];
    assign w_ncs_fall  = ~r_ncs_sync[SYNC_STAGES-1] &  r_ncs_sync[SYNC_STAGES];
    assign w_copi      = r_copi_sync[SYNC_STAGES-1];
    assign w_shift_bit = (r_state == ST_SHIFT) && !w_ncs_rise && w_sclk_rise;

    assign w_addr      = r_shift[14:8];
    assign w_commit_ok = (r_count == 5'd16) && r_shift[15] &&
                         (32'(w_addr) <= MAX_ADDR) && (w_addr < 7'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_ncs_fall) w_state_next = ST_SHIFT;
            ST_SHIFT:  if (w_ncs_rise) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            // NOTE: the register file is small and must read 0 after reset, so every entry is reset explicitly.
            for (int i = 0; i < 5; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if ((r_state == ST_IDLE) && w_ncs_fall) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_shift_bit) begin
                r_shift <= {r_shift[14:0], w_copi};
                if (r_count != 5'd17) begin
                    r_count <= r_count + 5'd1;
                end
            end
            if ((r_state == ST_COMMIT) && w_commit_ok) begin
                r_regs[w_addr[2:0]] <= r_shift[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];

`ifdef SPI_READBACK_EN
    logic       w_sclk_fall;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [7:0] r_tx;
    logic       r_rd;
    logic       r_cipo;

    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_sync[SYNC_STAGES];
    // On the 8th rise the address LSB is still on w_copi, not yet in the shift register.
    assign w_rd_addr   = {r_shift[5:0], w_copi};

    always_comb begin
        w_rd_data = 8'h00;
        if ((32'(w_rd_addr) <= MAX_ADDR) && (w_rd_addr < 7'd5)) begin
            w_rd_data = r_regs[w_rd_addr[2:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx   <= '0;
            r_rd   <= 1'b0;
            r_cipo <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            if (w_shift_bit && (r_count == 5'd7) && !r_shift[6]) begin
                r_rd <= 1'b1;
                r_tx <= w_rd_data;
            end
            if (w_sclk_fall) begin
                if (r_rd && (r_count >= 5'd8) && (r_count <= 5'd15)) begin
                    r_cipo <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end else begin
                    r_cipo <= 1'b0;
                end
            end
        end else begin
            r_rd   <= 1'b0;
            r_cipo <= 1'b0;
        end
    end

    assign cipo    = r_cipo;
    assign cipo_oe = (r_state == ST_SHIFT);
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_register_peripheral.sv
// Scoreboarded random/directed bench for spi_register_peripheral; the register
// model applies the frame rules directly, a monitor checks registers after each frame.
module tb_spi_register_peripheral;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic       cipo_oe;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    spi_register_peripheral #(
        .SYNC_STAGES(SYNC_STAGES),
        .MAX_ADDR(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sclk(sclk),
        .copi(copi),
        .ncs(ncs),
        .cipo(cipo),
        .cipo_oe(cipo_oe),
        .en_reg_out_7_0(en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    always #5 clk = ~clk;

`ifdef SPI_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic [7:0]  m_regs [5];
    logic [39:0] exp_q [$];
    event        frame_end;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] model_regs();
        return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    // Registers must hold the expected values exactly SYNC_STAGES+2 clocks after nCS rises.
    initial begin
        forever begin
            @(frame_end);
            repeat (SYNC_STAGES + 2) @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: register update with no expected entry at %0t", $time);
            end else begin
                check("regs_after_frame", dut_regs(), exp_q.pop_front());
            end
        end
    end

    task automatic frame(input logic [15:0] word, input int nbits);
        logic [7:0] rx;
        logic [7:0] exp_rd;
        int         a;
        rx     = 8'h00;
        a      = int'(word[14:8]);
        exp_rd = (READBACK && a <= 4) ? m_regs[a] : 8'h00;
        ncs    = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? word[15-i] : 1'b1;
            #HALF;
            if (i >= 8 && i < 16) rx[15-i] = cipo;
            if (i == 4) check("cipo_oe_in_frame", {39'd0, cipo_oe}, {39'd0, READBACK});
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        if (nbits == 16 && word[15] && a <= 4) m_regs[a] = word[7:0];
        exp_q.push_back(model_regs());
        ncs  = 1'b1;
        copi = 1'b0;
        -> frame_end;
        #(3 * HALF);
        check("cipo_oe_idle", {38'd0, cipo_oe, cipo}, 40'd0);
        if (!word[15] && nbits >= 16) check("readback", {32'd0, rx}, {32'd0, exp_rd});
        #HALF;
    endtask

    initial begin
        logic [15:0] w;
        int          n;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_regs", dut_regs(), 40'd0);
        check("reset_cipo", {38'd0, cipo_oe, cipo}, 40'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        frame(16'h80FF, 16);
        frame(16'h8440, 16);
        frame(16'h8555, 16);
        frame(16'h0177, 16);
        frame(16'h83AA, 15);
        frame(16'h83AA, 17);
        frame(16'h8233, 16);
        frame(16'h0200, 16);
        frame(16'h0455, 17);
        frame(16'h0700, 16);

        // Reset asserted in the middle of a frame aborts it and clears every register.
        ncs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            copi = 1'b1;
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        #20;
        check("regs_async_reset", dut_regs(), 40'd0);
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        exp_q.push_back(model_regs());
        ncs = 1'b1;
        -> frame_end;
        #(2 * HALF);
        rst_n = 1'b1;
        #(2 * HALF);
        frame(16'h8122, 16);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 9);
            n = (n < 2) ? 15 : (n < 4) ? 17 : 16;
            w[15]   = ($urandom_range(0, 2) != 0);
            w[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            w[7:0]  = 8'($urandom);
            frame(w, n);
        end

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never checked", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
